// File: rtl/monkey_state_ctrl.sv
// Monkey game-state controller: spawn, play, airborne, dying and game-over
// sequencing. Also gates keyboard keys to the movement block and tracks lives.
`timescale 1ns / 1ps
module monkey_state_ctrl #(
  parameter int unsigned START_LIVES  = 3,
  parameter int unsigned DEATH_FRAMES = 60,
  parameter int          FALL_LIMIT_Y = 440
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               startGame,
  input  logic               leftPressed,
  input  logic               rightPressed,
  input  logic               upPressed,
  input  logic               downPressed,
  input  logic               onRope,
  input  logic               onBlock,
  input  logic               hazardHit,
  input  logic signed [10:0] topLeftY,
  output logic               leftOut,
  output logic               rightOut,
  output logic               upOut,
  output logic               downOut,
  output logic               moveResetN,
  output logic [1:0]         lives,
  output logic               gameOver,
  output logic [2:0]         state
);

  // Wide enough to hold DEATH_FRAMES itself, never narrower than 6 bits.
  localparam int unsigned CntBits =
      ($clog2(DEATH_FRAMES + 1) > 6) ? $clog2(DEATH_FRAMES + 1) : 6;
  localparam logic [CntBits-1:0] LastFrame  = CntBits'(DEATH_FRAMES - 1);
  localparam logic [1:0]         StartLives = 2'(START_LIVES);
  localparam logic signed [10:0] FallLimit  = 11'(FALL_LIMIT_Y);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StSpawn    = 3'd1,
    StPlay     = 3'd2,
    StAir      = 3'd3,
    StDying    = 3'd4,
    StGameOver = 3'd5
  } stateT;

  stateT              stateQ;
  stateT              stateNext;
  logic [1:0]         livesQ;
  logic [CntBits-1:0] frameCnt;
  logic               upArmed;
  logic               upGate;
  logic               footing;
  logic               fellOff;
  logic               deathDone;

  assign footing   = onRope | onBlock;
  assign fellOff   = topLeftY > FallLimit;
  // The frame pulse that brings the counter up to DEATH_FRAMES ends DYING.
  assign deathDone = startOfFrame && (frameCnt >= LastFrame);

  // Next-state decode; hazard beats every other transition in PLAY/AIR.
  always_comb begin
    stateNext = stateQ;
    case (stateQ)
      StIdle:     if (startGame) stateNext = StSpawn;
      StSpawn:    if (startOfFrame) stateNext = StPlay;
      StPlay: begin
        if (hazardHit) stateNext = StDying;
        else if (startOfFrame && !footing) stateNext = StAir;
      end
      StAir: begin
        if (hazardHit) stateNext = StDying;
        else if (startOfFrame) begin
          if (footing) stateNext = StPlay;
          else if (fellOff) stateNext = StDying;
        end
      end
      StDying:    if (deathDone) stateNext = (livesQ == 2'd0) ? StGameOver : StSpawn;
      StGameOver: if (startGame) stateNext = StSpawn;
      default:    stateNext = StIdle;
    endcase
  end

  // Up passes while armed, or always on a rope so climbing is not throttled.
  always_comb begin
    upGate = upPressed & (onRope | upArmed) & (stateNext == StPlay);
  end

  // State, lives, death timer, jump arming and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stateQ     <= StIdle;
      livesQ     <= StartLives;
      frameCnt   <= '0;
      upArmed    <= 1'b1;
      leftOut    <= 1'b0;
      rightOut   <= 1'b0;
      upOut      <= 1'b0;
      downOut    <= 1'b0;
      moveResetN <= 1'b0;
      gameOver   <= 1'b0;
    end else begin
      stateQ <= stateNext;

      if (stateNext == StDying && stateQ != StDying) begin
        livesQ   <= (livesQ == 2'd0) ? 2'd0 : livesQ - 2'd1;
        frameCnt <= '0;
      end else if (stateQ == StDying && startOfFrame) begin
        frameCnt <= frameCnt + 1'b1;
      end
      if (stateQ == StGameOver && stateNext == StSpawn) livesQ <= StartLives;

      if (upGate && onBlock && !onRope) upArmed <= 1'b0;
      else if (!upPressed)              upArmed <= 1'b1;

      // Outputs are decoded from the state being entered so they line up with it.
      leftOut    <= leftPressed  & ((stateNext == StPlay) | (stateNext == StAir));
      rightOut   <= rightPressed & ((stateNext == StPlay) | (stateNext == StAir));
      downOut    <= downPressed  & (stateNext == StPlay);
      upOut      <= upGate;
      moveResetN <= (stateNext == StPlay) | (stateNext == StAir) | (stateNext == StDying);
      gameOver   <= (stateNext == StGameOver);
    end
  end

  assign lives = livesQ;
  assign state = stateQ;

endmodule

// File: tb/tb_monkey_state_ctrl.sv
// Self-checking bench for monkey_state_ctrl: vector table, hand-written corner
// sequences and a randomized run against a behavioural game model.
`timescale 1ns / 1ps
module tb_monkey_state_ctrl;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic startOfFrame = 1'b0, startGame = 1'b0;
  logic leftPressed = 1'b0, rightPressed = 1'b0, upPressed = 1'b0, downPressed = 1'b0;
  logic onRope = 1'b0, onBlock = 1'b0, hazardHit = 1'b0;
  logic signed [10:0] topLeftY = 11'sd100;
  logic leftOut, rightOut, upOut, downOut, moveResetN, gameOver;
  logic [1:0] lives;
  logic [2:0] state;

  int nChecks = 0;
  int nFail   = 0;

  monkey_state_ctrl dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .startGame(startGame),
    .leftPressed(leftPressed), .rightPressed(rightPressed), .upPressed(upPressed),
    .downPressed(downPressed), .onRope(onRope), .onBlock(onBlock), .hazardHit(hazardHit),
    .topLeftY(topLeftY), .leftOut(leftOut), .rightOut(rightOut), .upOut(upOut),
    .downOut(downOut), .moveResetN(moveResetN), .lives(lives), .gameOver(gameOver),
    .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit expired (actual=running required=finished)");
    $fatal(1);
  end

  // Behavioural game model: mode numbers, lives and a death countdown.
  int       mMode, mLives, mFramesLeft;
  bit       mArmed, mMr, mGo;
  bit [3:0] mKeys;

  task automatic modelReset();
    mMode = 0; mLives = 3; mFramesLeft = 0; mArmed = 1; mMr = 0; mGo = 0; mKeys = 4'b0;
  endtask

  task automatic modelStep();
    int nxt;
    int y;
    bit footing;
    bit upOk;
    bit mobile;
    nxt = mMode;
    y = topLeftY;
    footing = onRope || onBlock;
    case (mMode)
      0: if (startGame) nxt = 1;
      1: if (startOfFrame) nxt = 2;
      2, 3: begin
        if (hazardHit) nxt = 4;
        else if (startOfFrame) begin
          if (mMode == 2) begin
            if (!footing) nxt = 3;
          end else if (footing) nxt = 2;
          else if (y > 440) nxt = 4;
        end
      end
      4: if (startOfFrame) begin
        mFramesLeft = mFramesLeft - 1;
        if (mFramesLeft == 0) nxt = (mLives == 0) ? 5 : 1;
      end
      5: if (startGame) begin
        nxt = 1;
        mLives = 3;
      end
      default: nxt = 0;
    endcase
    if (nxt == 4 && mMode != 4) begin
      mLives = (mLives > 0) ? mLives - 1 : 0;
      mFramesLeft = 60;
    end
    mobile = (nxt == 2) || (nxt == 3);
    upOk = upPressed && (onRope || mArmed) && (nxt == 2);
    mKeys = {leftPressed && mobile, rightPressed && mobile, upOk, downPressed && (nxt == 2)};
    if (upOk && onBlock && !onRope) mArmed = 0;
    else if (!upPressed) mArmed = 1;
    mMr = (nxt == 2) || (nxt == 3) || (nxt == 4);
    mGo = (nxt == 5);
    mMode = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic checkOne(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkOuts(input string tag, input int st, input int lv, input int keys,
                           input int mr, input int go);
    checkOne({tag, ".state"}, int'(state), st);
    checkOne({tag, ".lives"}, int'(lives), lv);
    checkOne({tag, ".keys"}, int'({leftOut, rightOut, upOut, downOut}), keys);
    checkOne({tag, ".moveResetN"}, int'(moveResetN), mr);
    checkOne({tag, ".gameOver"}, int'(gameOver), go);
  endtask

  task automatic setKeys(input logic [3:0] k);
    {leftPressed, rightPressed, upPressed, downPressed} = k;
  endtask

  task automatic doReset();
    @(negedge clk);
    resetN = 1'b0;
    modelReset();
    #1;
    checkOuts("reset", 0, 3, 0, 0, 0);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
    end
  endtask

  typedef struct {
    bit       sg;
    bit       sof;
    bit [3:0] keys;
    bit       rope;
    bit       block;
    bit       hz;
    int       y;
    int       eState;
    int       eLives;
    bit [3:0] eKeys;
    bit       eMr;
    bit       eGo;
  } vecT;

  vecT vecs[12];

  initial begin
    int cnt;
    // keys = {left,right,up,down}
    vecs[0]  = '{1, 0, 4'b1111, 0, 1, 0, 100, 1, 3, 4'b0000, 0, 0};
    vecs[1]  = '{0, 1, 4'b1010, 0, 1, 0, 100, 2, 3, 4'b1010, 1, 0};
    vecs[2]  = '{0, 0, 4'b1110, 0, 1, 0, 100, 2, 3, 4'b1100, 1, 0};
    vecs[3]  = '{0, 0, 4'b0101, 0, 1, 0, 100, 2, 3, 4'b0101, 1, 0};
    vecs[4]  = '{0, 0, 4'b0010, 0, 1, 0, 100, 2, 3, 4'b0010, 1, 0};
    vecs[5]  = '{0, 1, 4'b1111, 0, 0, 0, 100, 3, 3, 4'b1100, 1, 0};
    vecs[6]  = '{0, 0, 4'b0101, 0, 0, 0, 100, 3, 3, 4'b0100, 1, 0};
    vecs[7]  = '{0, 1, 4'b0000, 1, 0, 0, 100, 2, 3, 4'b0000, 1, 0};
    vecs[8]  = '{0, 1, 4'b0000, 0, 0, 0, 441, 3, 3, 4'b0000, 1, 0};
    vecs[9]  = '{0, 1, 4'b0000, 0, 0, 0, 440, 3, 3, 4'b0000, 1, 0};
    vecs[10] = '{0, 1, 4'b1111, 0, 0, 0, 441, 4, 2, 4'b0000, 1, 0};
    vecs[11] = '{1, 0, 4'b0000, 0, 0, 0, 441, 4, 2, 4'b0000, 1, 0};

    modelReset();
    doReset();

    for (int i = 0; i < 12; i++) begin
      startGame = vecs[i].sg;
      startOfFrame = vecs[i].sof;
      setKeys(vecs[i].keys);
      onRope = vecs[i].rope;
      onBlock = vecs[i].block;
      hazardHit = vecs[i].hz;
      topLeftY = 11'(vecs[i].y);
      tick();
      checkOuts($sformatf("vec%0d", i), vecs[i].eState, vecs[i].eLives, int'(vecs[i].eKeys),
                int'(vecs[i].eMr), int'(vecs[i].eGo));
    end
    startGame = 1'b0;
    startOfFrame = 1'b0;
    setKeys(4'b0000);
    topLeftY = 11'sd100;

    // Death timer: 59 frames stay in DYING, the 60th respawns.
    frames(59);
    checkOne("dying_59", int'(state), 4);
    frames(1);
    checkOuts("respawn", 1, 2, 0, 0, 0);

    // One jump per press on a block; rope climbing unthrottled.
    onBlock = 1'b1;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    checkOne("play_entry", int'(state), 2);
    for (int pass = 0; pass < 2; pass++) begin
      cnt = 0;
      setKeys(4'b0010);
      for (int i = 0; i < 20; i++) begin
        tick();
        if (upOut) cnt++;
      end
      checkOne($sformatf("jump_pulse%0d", pass), cnt, 1);
      setKeys(4'b0000);
      tick();
    end
    onBlock = 1'b0;
    onRope = 1'b1;
    setKeys(4'b0010);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (upOut) cnt++;
    end
    checkOne("rope_climb", cnt, 10);
    setKeys(4'b0000);

    // Lose a life, then hazard and footing loss together on the last life.
    hazardHit = 1'b1;
    tick();
    hazardHit = 1'b0;
    checkOuts("hazard1", 4, 1, 0, 1, 0);
    frames(60);
    checkOne("respawn2", int'(state), 1);
    startOfFrame = 1'b1;
    tick();
    checkOne("play2", int'(state), 2);
    hazardHit = 1'b1;
    onRope = 1'b0;
    tick();
    hazardHit = 1'b0;
    startOfFrame = 1'b0;
    checkOuts("hazard_prio", 4, 0, 0, 1, 0);
    frames(60);
    checkOuts("game_over", 5, 0, 0, 0, 1);
    startGame = 1'b1;
    tick();
    startGame = 1'b0;
    checkOuts("restart", 1, 3, 0, 0, 0);

    // Asynchronous reset in the middle of DYING.
    onBlock = 1'b1;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    hazardHit = 1'b1;
    tick();
    hazardHit = 1'b0;
    checkOne("dying3.lives", int'(lives), 2);
    frames(5);
    #2;
    resetN = 1'b0;
    modelReset();
    #1;
    checkOuts("async_reset", 0, 3, 0, 0, 0);
    @(negedge clk);
    resetN = 1'b1;

    // Randomized run against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) doReset();
      startGame = ($urandom_range(0, 15) == 0);
      startOfFrame = ($urandom_range(0, 3) == 0);
      setKeys(4'($urandom_range(0, 15)));
      onRope = ($urandom_range(0, 3) == 0);
      onBlock = ($urandom_range(0, 1) == 0);
      hazardHit = ($urandom_range(0, 149) == 0);
      case ($urandom_range(0, 4))
        0: topLeftY = 11'sd100;
        1: topLeftY = 11'sd440;
        2: topLeftY = 11'sd441;
        3: topLeftY = -11'sd5;
        default: topLeftY = 11'($urandom_range(0, 1023));
      endcase
      tick();
      checkOuts("rand", mMode, mLives, int'(mKeys), int'(mMr), int'(mGo));
    end

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end

endmodule
